// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares one register-bank access port between NREQ requesters.
// Round-robin arbitration with optional locked bursts (capped at MAX_BURST beats).
// Grants and bank commands are registered; read data is registered one cycle later.
// Optional macro REG_ARB_PRIO_EN: requester 0 takes fixed top priority while arbitrating.
module reg_bank_arbiter #(
    parameter int unsigned WL        = 32,
    parameter int unsigned AL        = 5,
    parameter int unsigned NREQ      = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ-1:0]    req_lock_i,
    input  logic [NREQ*AL-1:0] req_addr_i,
    input  logic [NREQ*WL-1:0] req_wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [WL-1:0]      rsp_data_o,
    output logic               rb_wr_en_o,
    output logic               rb_rd_en_o,
    output logic [AL-1:0]      rb_addr_o,
    output logic [WL-1:0]      rb_wdata_o,
    input  logic [WL-1:0]      rb_rdata_i
);

    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [0:0] {StArb, StOwned} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [3:0]      burst_q, burst_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rb_wr_en_q, rb_wr_en_d;
    logic            rb_rd_en_q, rb_rd_en_d;
    logic [AL-1:0]   rb_addr_q, rb_addr_d;
    logic [WL-1:0]   rb_wdata_q, rb_wdata_d;
    logic [NREQ-1:0] rsp_valid_q;
    logic [WL-1:0]   rsp_data_q;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] owner_mask;
    logic            found;
    logic            prio_hit;
    logic [PW-1:0]   win;
    int unsigned     idx;
    int unsigned     nxt;

    // Winner selection, FSM next state and the registered bank command.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        gnt_d      = '0;
        rb_wr_en_d = 1'b0;
        rb_rd_en_d = 1'b0;
        rb_addr_d  = rb_addr_q;
        rb_wdata_d = rb_wdata_q;
        found      = 1'b0;
        prio_hit   = 1'b0;
        win        = '0;
        idx        = 0;
        nxt        = 0;
        owner_mask = '0;

        // A beat whose grant is visible now must not be issued twice.
        elig = req_i & ~gnt_q;
        if (state_q == StOwned) begin
            owner_mask[owner_q] = 1'b1;
            elig = elig & owner_mask;
        end

`ifdef REG_ARB_PRIO_EN
        if (state_q == StArb && elig[0]) begin
            found    = 1'b1;
            prio_hit = 1'b1;
            win      = '0;
        end
`endif

        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        if (found) begin
            gnt_d[win] = 1'b1;
            rb_wr_en_d = req_we_i[win];
            rb_rd_en_d = ~req_we_i[win];
            rb_addr_d  = req_addr_i[win*AL +: AL];
            rb_wdata_d = req_wdata_i[win*WL +: WL];
            // Pointer moves past the winner, which also covers forced release.
            if (!prio_hit) begin
                nxt   = (32'(win) + 1) % NREQ;
                ptr_d = PW'(nxt);
            end
            if (state_q == StArb) begin
                if (req_lock_i[win] && MAX_BURST > 1) begin
                    state_d = StOwned;
                    owner_d = win;
                    burst_d = 4'd1;
                end
            end else begin
                if (!req_lock_i[win] || (burst_q + 4'd1) >= 4'(MAX_BURST)) begin
                    state_d = StArb;
                    burst_d = 4'd0;
                end else begin
                    burst_d = burst_q + 4'd1;
                end
            end
        end else if (state_q == StOwned && !req_i[owner_q]) begin
            state_d = StArb;
            burst_d = 4'd0;
        end
    end

    // Arbiter state, grant and bank command registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StArb;
            ptr_q      <= '0;
            owner_q    <= '0;
            burst_q    <= 4'd0;
            gnt_q      <= '0;
            rb_wr_en_q <= 1'b0;
            rb_rd_en_q <= 1'b0;
            rb_addr_q  <= '0;
            rb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            gnt_q      <= gnt_d;
            rb_wr_en_q <= rb_wr_en_d;
            rb_rd_en_q <= rb_rd_en_d;
            rb_addr_q  <= rb_addr_d;
            rb_wdata_q <= rb_wdata_d;
        end
    end

    // Capture read data during the read grant; pulse rsp_valid to that requester next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rb_rd_en_q ? gnt_q : '0;
            if (rb_rd_en_q) begin
                rsp_data_q <= rb_rdata_i;
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rb_wr_en_o  = rb_wr_en_q;
    assign rb_rd_en_o  = rb_rd_en_q;
    assign rb_addr_o   = rb_addr_q;
    assign rb_wdata_o  = rb_wdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed testbench for reg_bank_arbiter with a small register-bank model.
module tb_reg_bank_arbiter;

    localparam int unsigned WL   = 32;
    localparam int unsigned AL   = 5;
    localparam int unsigned NREQ = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req, req_we, req_lock;
    logic [NREQ*AL-1:0] req_addr;
    logic [NREQ*WL-1:0] req_wdata;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic [WL-1:0]      rsp_data;
    logic               rb_wr_en, rb_rd_en;
    logic [AL-1:0]      rb_addr;
    logic [WL-1:0]      rb_wdata, rb_rdata;

    logic [WL-1:0]      mem [32];
    logic               load;

    int errors = 0;
    int checks = 0;

    reg_bank_arbiter #(.WL(WL), .AL(AL), .NREQ(NREQ), .MAX_BURST(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rb_wr_en_o  (rb_wr_en),
        .rb_rd_en_o  (rb_rd_en),
        .rb_addr_o   (rb_addr),
        .rb_wdata_o  (rb_wdata),
        .rb_rdata_i  (rb_rdata)
    );

    always #5 clk = ~clk;

    // Bank model: preload on load, otherwise write on rb_wr_en.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (rb_wr_en) begin
            mem[rb_addr] <= rb_wdata;
        end
    end
    assign rb_rdata = mem[rb_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic we, input logic lk,
                           input logic [AL-1:0] a, input logic [WL-1:0] d);
        req[i]             = r;
        req_we[i]          = we;
        req_lock[i]        = lk;
        req_addr[i*AL +: AL] = a;
        req_wdata[i*WL +: WL] = d;
    endtask

    task automatic do_reset;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (gnt !== 3'b000 || rsp_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_hs: gnt=%b rsp_valid=%b required 000 000", gnt, rsp_valid);
        end
        checks++;
        if (rb_wr_en !== 1'b0 || rb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: wr=%b rd=%b required 0 0", rb_wr_en, rb_rd_en);
        end
        checks++;
        if (rb_addr !== 5'd0 || rb_wdata !== 32'd0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rsp=%h required 0", rb_addr, rb_wdata,
                     rsp_data);
        end
    endtask

    task automatic test_write_read;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (gnt !== 3'b001 || rb_wr_en !== 1'b1 || rb_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt: gnt=%b wr=%b rd=%b required 001 1 0", gnt, rb_wr_en, rb_rd_en);
        end
        checks++;
        if (rb_addr !== 5'd5 || rb_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_cmd: addr=%h wdata=%h required 05 deadbeef", rb_addr, rb_wdata);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 5'd5, 32'd0);
        tick();
        checks++;
        if (gnt !== 3'b010 || rb_rd_en !== 1'b1 || rb_wr_en !== 1'b0 || rb_addr !== 5'd5) begin
            errors++;
            $display("FAIL rd_gnt: gnt=%b rd=%b wr=%b addr=%h required 010 1 0 05", gnt, rb_rd_en,
                     rb_wr_en, rb_addr);
        end
        checks++;
        if (rsp_valid !== 3'b000) begin
            errors++;
            $display("FAIL wr_norsp: rsp_valid=%b required 000", rsp_valid);
        end
        set_req(1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'hDEAD_BEEF || gnt !== 3'b000) begin
            errors++;
            $display("FAIL rd_rsp: rsp_valid=%b data=%h gnt=%b required 010 deadbeef 000",
                     rsp_valid, rsp_data, gnt);
        end
        tick();
        checks++;
        if (rsp_valid !== 3'b000 || rsp_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rsp_hold: rsp_valid=%b data=%h required 000 deadbeef", rsp_valid,
                     rsp_data);
        end
        checks++;
        if (rb_wr_en !== 1'b0 || rb_rd_en !== 1'b0 || rb_addr !== 5'd5) begin
            errors++;
            $display("FAIL idle_hold: wr=%b rd=%b addr=%h required 0 0 05", rb_wr_en, rb_rd_en,
                     rb_addr);
        end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] exp_gnt [4];
        logic [NREQ-1:0] exp_rsp [4];
        logic [AL-1:0]   exp_addr [4];
        exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rsp  = '{3'b000, 3'b001, 3'b010, 3'b100};
        exp_addr = '{5'd1, 5'd2, 5'd3, 5'd1};
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, AL'(i + 1), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt[c] || rb_addr !== exp_addr[c] || rb_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: gnt=%b addr=%h rd=%b required %b %h 1", c, gnt,
                         rb_addr, rb_rd_en, exp_gnt[c], exp_addr[c]);
            end
            checks++;
            if (rsp_valid !== exp_rsp[c] ||
                (c > 0 && rsp_data !== (32'hA500_0000 | 32'(c)))) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: rsp_valid=%b data=%h required %b a500000%0d", c,
                         rsp_valid, rsp_data, exp_rsp[c], c);
            end
        end
        req = '0;
    endtask

    task automatic test_locked_burst;
        logic [NREQ-1:0] exp_gnt [9];
        exp_gnt = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b001, 3'b010};
        do_reset();
        set_req(1, 1'b1, 1'b0, 1'b1, 5'd7, 32'd0);
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) set_req(0, 1'b1, 1'b0, 1'b0, 5'd8, 32'd0);
            checks++;
            if (gnt !== exp_gnt[c]) begin
                errors++;
                $display("FAIL lock_gnt[%0d]: gnt=%b required %b", c, gnt, exp_gnt[c]);
            end
        end
        req = '0; req_lock = '0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd0);
        tick();
        checks++;
        if (rb_rd_en !== 1'b1 || gnt !== 3'b001) begin
            errors++;
            $display("FAIL mid_pre: rd=%b gnt=%b required 1 001", rb_rd_en, gnt);
        end
        rst_n = 1'b0;
        req = '0;
        #1;
        checks++;
        if (gnt !== 3'b000 || rb_rd_en !== 1'b0 || rsp_valid !== 3'b000) begin
            errors++;
            $display("FAIL mid_async: gnt=%b rd=%b rsp_valid=%b required 000 0 000", gnt,
                     rb_rd_en, rsp_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 3'b000 || rsp_data !== 32'd0 || rb_addr !== 5'd0 || gnt !== 3'b000) begin
            errors++;
            $display("FAIL mid_after: rsp_valid=%b data=%h addr=%h gnt=%b required 000 0 0 000",
                     rsp_valid, rsp_data, rb_addr, gnt);
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, AL'(i + 1), 32'd0);
        tick();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL mid_ptr: gnt=%b required 001", gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_withdraw;
        int bad;
        bad = 0;
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 5'd9, 32'd0);
        tick();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL wd_owner: gnt=%b required 001", gnt);
        end
        set_req(2, 1'b1, 1'b1, 1'b0, 5'd20, 32'h1234_5678);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (gnt[2] === 1'b1 || ((rb_wr_en | rb_rd_en) === 1'b1 && rb_addr === 5'd20)) bad++;
        end
        req[2] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (gnt[2] === 1'b1 || ((rb_wr_en | rb_rd_en) === 1'b1 && rb_addr === 5'd20)) bad++;
        end
        req[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (gnt[2] === 1'b1 || ((rb_wr_en | rb_rd_en) === 1'b1 && rb_addr === 5'd20)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wd_nogrant: withdrawn beat issued %0d times, required 0", bad);
        end
        checks++;
        if (mem[20] !== (32'hA500_0000 | 32'd20)) begin
            errors++;
            $display("FAIL wd_mem: mem[20]=%h required a5000014", mem[20]);
        end
        req_lock = '0;
    endtask

`ifdef REG_ARB_PRIO_EN
    task automatic test_priority;
        logic [NREQ-1:0] exp_gnt [6];
        exp_gnt = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, AL'(i + 1), 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt[c]) begin
                errors++;
                $display("FAIL prio_gnt[%0d]: gnt=%b required %b", c, gnt, exp_gnt[c]);
            end
        end
        req = '0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        load = 1'b1;
        tick();
        load = 1'b0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_locked_burst();
        test_reset_mid();
        test_withdraw();
`ifdef REG_ARB_PRIO_EN
        test_priority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single access port of a register bank between NREQ requesters; one bank access per cycle.
Requesters issue read or write beats with a req/gnt handshake. Arbitration is round-robin, with optional locked bursts.
The block drives the bank's write/read-enable, address and write-data lines, and returns registered read data to the requester that issued the read.
It sits between the pipeline/DMA masters and the register bank.

Parameters:
WL, 32, register word length
AL, 5, register address width
NREQ, 3, number of requesters (2..8)
MAX_BURST, 4, maximum consecutive beats a locked owner may take before forced release (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester beat request
req_we  in  NREQ  1 = write beat, 0 = read beat
req_lock  in  NREQ  request to keep ownership for the following beats
req_addr  in  NREQ*AL  flattened addresses; requester i uses bits [i*AL +: AL]
req_wdata  in  NREQ*WL  flattened write data; requester i uses bits [i*WL +: WL]
gnt  out  NREQ  one-hot grant pulse; marks the cycle the beat is driven to the bank
rsp_valid  out  NREQ  one-hot read-response pulse
rsp_data  out  WL  read data
rb_wr_en  out  1  bank write enable
rb_rd_en  out  1  bank read enable
rb_addr  out  AL  bank address (drives both write and read address)
rb_wdata  out  WL  bank write data
rb_rdata  in  WL  bank read data; combinational from rb_addr

Behaviour:
- Interface: one clock `clk`, with asynchronous active-low reset `rst_n`.
- Reset (asynchronous, active-low): all outputs 0; RR pointer = 0; state = ARB; burst count = 0; any pending read response is discarded.
- Arbitration and issue timing:
  - Cycle n: sample eligible = req & ~gnt. Masking with the current gnt prevents double issue of a beat whose grant is visible this cycle.
  - Cycle n+1: winner i has gnt[i]=1 for exactly one cycle. The arbiter registers i's command onto rb_*: rb_wr_en=req_we[i], rb_rd_en=~req_we[i], rb_addr, rb_wdata.
  - rb_wr_en and rb_rd_en are never high together. With no grant, both enables are 0 and rb_addr/rb_wdata hold their last values.
- Requester rules: hold req, req_we, req_addr, req_wdata and req_lock stable from assertion until gnt is seen. Dropping req before gnt withdraws the beat, and no access occurs.
- Read response: in a cycle with rb_rd_en=1, rb_rdata is registered into rsp_data. In the next cycle, rsp_valid[i]=1 for exactly one cycle. rsp_data holds until the next read response. Write beats produce no rsp_valid.
- Round-robin: the search starts at the pointer and wraps NREQ-1 -> 0. After each grant the pointer becomes (winner+1) mod NREQ.
- State machine:
  - ARB: round-robin over all eligible requesters. If the winner has req_lock=1, go to OWNED with owner=winner and burst count=1.
  - OWNED: only the owner is eligible; other requests wait.
  - Each owner grant increments burst count.
  - Return to ARB when any of these is sampled: the owner's granted beat has req_lock=0; the owner's req=0; burst count reaches MAX_BURST.
  - On a forced release at MAX_BURST, the pointer = owner+1, so the owner is not immediately re-granted if others are requesting.
- Throughput: any one requester gets at most one beat per two cycles. With several requesters active, the port can be used every cycle.
- Reset mid-operation: gnt, rb_* enables and rsp_valid drop to 0 immediately. The interrupted beat is either completed or not completed; no partial response is ever signalled.

Optional Feature:
REG_ARB_PRIO_EN:
- Defined: requester 0 is fixed highest priority in ARB. When eligible it wins regardless of the pointer, and the pointer is left unchanged. OWNED behaviour is unchanged, so requester 0 waits for a locked burst to end.
- Undefined: pure round-robin as above.

Test Plan:
- Write then read: req0 writes 0xDEADBEEF to addr 5; then req1 reads addr 5 -> rb_wr_en one pulse with rb_addr=5; then gnt[1]; rsp_valid[1] one cycle later with rsp_data=0xDEADBEEF.
- All three req high from reset, unlocked, reads -> gnt order 0,1,2,0 on consecutive cycles 1..4; each rsp_valid follows its gnt by one cycle.
- req1 locked (req_lock[1]=1, MAX_BURST=4), req0 also high -> four gnt[1] beats with no gnt[0] between; then gnt[0]; then req1 resumes only after req0.
- rst_n pulled low in the cycle rb_rd_en=1 -> rsp_valid stays 0; after release all outputs are 0 and the pointer is 0.
- req2 raised, then dropped before its gnt while req0 is owner -> no gnt[2] and no bank access with req2's address.
- REG_ARB_PRIO_EN defined, req0/req1/req2 all continuously high -> gnt[0] on every other cycle; req1/req2 alternate in the remaining slots.
